// File: rtl/pay_pkg.sv
// Shared types and constants for the coin-payment collector.
// Holds the FSM state enum, BCD digit type, coin values and the default credit ceiling.
package pay_pkg;

    typedef enum logic [1:0] {
        ST_COLLECT = 2'd0,
        ST_PAID    = 2'd1,
        ST_REFUND  = 2'd2
    } state_t;

    typedef logic [3:0] bcd_t;

    localparam int COIN1_VAL   = 1;
    localparam int COIN5_VAL   = 5;
    localparam int COIN10_VAL  = 10;
    localparam int MAXPAID_DEF = 99;

endpackage

// File: rtl/coin_debounce.sv
// Synchronizes one coin button and emits a single 1-cycle pulse per press.
// Pulse appears 2 + DEBOUNCE cycles after the button rises; no backpressure.
module coin_debounce #(
    parameter int DEBOUNCE = 20
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn,
    output logic pulse
);

    localparam int CW = $clog2(DEBOUNCE + 1);
    localparam logic [CW-1:0] LAST = CW'(DEBOUNCE - 1);

    logic          sync1;
    logic          sync2;
    logic [CW-1:0] cnt;
    logic          fired;

    // While armed, cnt counts consecutive high cycles; once fired, it counts
    // consecutive low cycles before the one-shot may fire again.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            cnt   <= '0;
            fired <= 1'b0;
            pulse <= 1'b0;
        end else begin
            sync1 <= btn;
            sync2 <= sync1;
            pulse <= 1'b0;
            if (!fired) begin
                if (sync2) begin
                    if (cnt == LAST) begin
                        pulse <= 1'b1;
                        fired <= 1'b1;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end else begin
                    cnt <= '0;
                end
            end else begin
                if (!sync2) begin
                    if (cnt == LAST) begin
                        fired <= 1'b0;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end else begin
                    cnt <= '0;
                end
            end
        end
    end

endmodule

// File: rtl/pay_collect.sv
// Accumulates debounced coin credits in BCD and settles as PAID (with change) or REFUND.
// Credit visible 1 cycle after its pulse, PAID/REFUND 1 cycle after the condition; no backpressure.
module pay_collect
    import pay_pkg::*;
#(
    parameter int DEBOUNCE = 20,
    parameter int MAXPAID  = MAXPAID_DEF
) (
    input  logic       clk,
    input  logic       EN,
    input  logic       coin1,
    input  logic       coin5,
    input  logic       coin10,
    input  logic [3:0] costone,
    input  logic [3:0] costten,
    input  logic       cancel,
    output logic [3:0] paidone,
    output logic [3:0] paidten,
    output logic [3:0] changeone,
    output logic [3:0] changeten,
    output logic       paid_ok,
    output logic       refund
);

    localparam int MAX_CAP = (MAXPAID > 99) ? 99 : MAXPAID;
    localparam logic [7:0] MAX_LIM = 8'(MAX_CAP);

    state_t state;
    logic   p1, p5, p10;

    coin_debounce #(.DEBOUNCE(DEBOUNCE)) u_coin1  (.clk(clk), .rst_n(EN), .btn(coin1),  .pulse(p1));
    coin_debounce #(.DEBOUNCE(DEBOUNCE)) u_coin5  (.clk(clk), .rst_n(EN), .btn(coin5),  .pulse(p5));
    coin_debounce #(.DEBOUNCE(DEBOUNCE)) u_coin10 (.clk(clk), .rst_n(EN), .btn(coin10), .pulse(p10));

    bcd_t       inc_one, inc_ten;
    bcd_t       os_raw, sum_one, sum_ten;
    logic       carry;
    logic [7:0] sum_bin;
    logic       credit_ok;
    logic       price_ok, paid_ge;
    logic       borrow;
    bcd_t       diff_one, diff_ten;

    always_comb begin
        // Only the highest-value simultaneous pulse is credited.
        inc_one = 4'd0;
        inc_ten = 4'd0;
        if (p10) begin
            inc_ten = bcd_t'(COIN10_VAL / 10);
        end else if (p5) begin
            inc_one = bcd_t'(COIN5_VAL);
        end else if (p1) begin
            inc_one = bcd_t'(COIN1_VAL);
        end

        // inc_one is at most 5, so the ones sum fits in 4 bits before correction.
        os_raw    = paidone + inc_one;
        carry     = (os_raw > 4'd9);
        sum_one   = carry ? (os_raw - 4'd10) : os_raw;
        sum_ten   = paidten + inc_ten + {3'b000, carry};
        sum_bin   = ({4'b0000, sum_ten} * 8'd10) + {4'b0000, sum_one};
        credit_ok = (p1 | p5 | p10) && (sum_ten <= 4'd9) && (sum_bin <= MAX_LIM);

        price_ok = (costone <= 4'd9) && (costten <= 4'd9) &&
                   !((costone == 4'd0) && (costten == 4'd0));
        paid_ge  = (paidten > costten) || ((paidten == costten) && (paidone >= costone));

        borrow   = (paidone < costone);
        diff_one = borrow ? (paidone + 4'd10 - costone) : (paidone - costone);
        diff_ten = paidten - costten - {3'b000, borrow};
    end

    always_ff @(posedge clk or negedge EN) begin
        if (!EN) begin
            state     <= ST_COLLECT;
            paidone   <= 4'd0;
            paidten   <= 4'd0;
            changeone <= 4'd0;
            changeten <= 4'd0;
            paid_ok   <= 1'b0;
            refund    <= 1'b0;
        end else begin
            case (state)
                ST_COLLECT: begin
                    // Cancel wins over both payment completion and a same-cycle credit.
                    if (cancel) begin
                        state     <= ST_REFUND;
                        changeone <= paidone;
                        changeten <= paidten;
                        refund    <= 1'b1;
                    end else if (price_ok && paid_ge) begin
                        state     <= ST_PAID;
                        changeone <= diff_one;
                        changeten <= diff_ten;
                        paid_ok   <= 1'b1;
                    end else if (credit_ok) begin
                        paidone <= sum_one;
                        paidten <= sum_ten;
                    end
                end
                default: begin
                    state <= state;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_pay_collect.sv
// Directed plus randomized bench for pay_collect against a behavioural payment model.
// Model tracks paid/change as plain integers and a settled/collecting status.
module tb_pay_collect;

    localparam int DEB = 4;

    logic       clk = 1'b0;
    logic       EN = 1'b0;
    logic       coin1 = 1'b0, coin5 = 1'b0, coin10 = 1'b0;
    logic [3:0] costone = 4'd0, costten = 4'd0;
    logic       cancel = 1'b0;
    logic [3:0] paidone, paidten, changeone, changeten;
    logic       paid_ok, refund;

    pay_collect #(.DEBOUNCE(DEB)) dut (
        .clk(clk), .EN(EN), .coin1(coin1), .coin5(coin5), .coin10(coin10),
        .costone(costone), .costten(costten), .cancel(cancel),
        .paidone(paidone), .paidten(paidten), .changeone(changeone),
        .changeten(changeten), .paid_ok(paid_ok), .refund(refund)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // Model: 0 = collecting, 1 = paid, 2 = refunded.
    int mstate, mpaid, mchange, mten, mone;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, "/paidten"},   {4'b0, paidten},   8'(mpaid / 10));
        chk({tag, "/paidone"},   {4'b0, paidone},   8'(mpaid % 10));
        chk({tag, "/changeten"}, {4'b0, changeten}, 8'(mchange / 10));
        chk({tag, "/changeone"}, {4'b0, changeone}, 8'(mchange % 10));
        chk({tag, "/paid_ok"},   {7'b0, paid_ok},   8'(mstate == 1));
        chk({tag, "/refund"},    {7'b0, refund},    8'(mstate == 2));
    endtask

    function automatic bit price_valid();
        return (mten <= 9) && (mone <= 9) && !(mten == 0 && mone == 0);
    endfunction

    task automatic settle();
        if (mstate == 0 && price_valid() && mpaid >= mten * 10 + mone) begin
            mstate  = 1;
            mchange = mpaid - (mten * 10 + mone);
        end
    endtask

    task automatic set_price(input int ten, input int one);
        @(negedge clk);
        costten = 4'(ten);
        costone = 4'(one);
        mten = ten;
        mone = one;
        repeat (3) @(negedge clk);
        settle();
    endtask

    task automatic do_reset(input string tag);
        @(negedge clk);
        EN = 1'b0;
        coin1 = 1'b0; coin5 = 1'b0; coin10 = 1'b0; cancel = 1'b0;
        repeat (3) @(negedge clk);
        mstate = 0; mpaid = 0; mchange = 0;
        check_all(tag);
        EN = 1'b1;
        @(negedge clk);
    endtask

    task automatic press(input logic [2:0] mask, input int hold);
        int v;
        @(negedge clk);
        coin1 = mask[0]; coin5 = mask[1]; coin10 = mask[2];
        repeat (hold) @(negedge clk);
        coin1 = 1'b0; coin5 = 1'b0; coin10 = 1'b0;
        repeat (12) @(negedge clk);
        if (hold >= DEB && mstate == 0) begin
            v = mask[2] ? 10 : (mask[1] ? 5 : 1);
            if (mpaid + v <= 99) mpaid += v;
        end
        settle();
    endtask

    task automatic do_cancel();
        @(negedge clk);
        cancel = 1'b1;
        @(negedge clk);
        cancel = 1'b0;
        repeat (2) @(negedge clk);
        if (mstate == 0) begin
            mstate  = 2;
            mchange = mpaid;
        end
    endtask

    initial begin
        bit found;
        mten = 0; mone = 0;

        // Price 25: 10, 20, 25 then PAID with zero change.
        do_reset("rst_a");
        set_price(2, 5);
        press(3'b100, 6); check_all("p25_c10a");
        press(3'b100, 6); check_all("p25_c10b");
        press(3'b010, 6); check_all("p25_c5");

        // Price 12: overpay gives change 03; later credits ignored.
        do_reset("rst_b");
        set_price(1, 2);
        press(3'b100, 6); check_all("p12_c10");
        press(3'b010, 6); check_all("p12_c5");
        press(3'b001, 6); check_all("p12_after_paid");

        // Price 30: cancel refunds current credit.
        do_reset("rst_c");
        set_price(3, 0);
        press(3'b010, 6); check_all("p30_c5");
        do_cancel();      check_all("p30_cancel");
        press(3'b100, 6); check_all("p30_terminal");

        // Cancel coincident with a coin10 pulse: that credit is dropped.
        do_reset("rst_d");
        set_price(3, 0);
        press(3'b010, 6);
        @(negedge clk);
        coin10 = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            @(negedge clk);
            if (dut.u_coin10.pulse) found = 1'b1;
        end
        chk("race_pulse_seen", {7'b0, found}, 8'd1);
        cancel = 1'b1;
        @(negedge clk);
        cancel = 1'b0;
        coin10 = 1'b0;
        repeat (12) @(negedge clk);
        mstate = 2; mchange = mpaid;
        check_all("race_cancel");

        // Glitches never credit; a long hold credits exactly once.
        do_reset("rst_e");
        set_price(5, 0);
        press(3'b001, 1);
        press(3'b001, 1);
        press(3'b001, 3); check_all("glitch");
        press(3'b001, 50); check_all("long_hold");

        // Invalid price 00: never PAID, ceiling at 99.
        do_reset("rst_f");
        set_price(0, 0);
        for (int i = 0; i < 9; i++) press(3'b100, 6);
        check_all("p00_90");
        press(3'b100, 6); check_all("p00_ceiling");
        press(3'b010, 6); check_all("p00_95");

        // Reset mid-debounce discards; held button credits once after release of reset.
        do_reset("rst_g");
        set_price(9, 9);
        @(negedge clk);
        coin10 = 1'b1;
        repeat (5) @(negedge clk);
        EN = 1'b0;
        repeat (2) @(negedge clk);
        check_all("en_low_mid");
        EN = 1'b1;
        repeat (15) @(negedge clk);
        mpaid = 10;
        check_all("en_high_held");
        repeat (20) @(negedge clk);
        check_all("en_held_once");
        coin10 = 1'b0;
        repeat (10) @(negedge clk);

        // Randomized episodes: random prices (some invalid), presses, overlaps and cancels.
        for (int ep = 0; ep < 20; ep++) begin
            do_reset($sformatf("rnd%0d_rst", ep));
            if ($urandom_range(0, 4) == 0)
                set_price($urandom_range(10, 15), $urandom_range(0, 9));
            else
                set_price($urandom_range(0, 9), $urandom_range(0, 9));
            for (int a = 0; a < 8; a++) begin
                case ($urandom_range(0, 9))
                    0:       do_cancel();
                    1:       set_price($urandom_range(0, 9), $urandom_range(0, 9));
                    default: press(3'($urandom_range(1, 7)), $urandom_range(1, 10));
                endcase
                check_all($sformatf("rnd%0d_a%0d", ep, a));
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pay_collect.md
PAY_COLLECT -- requirements
Module: pay_collect

Interface
REQ-001 Parameter DEBOUNCE, default 20: consecutive clk cycles a synchronized coin input must stay high before it is credited.
REQ-002 Parameter MAXPAID, default 99: the credit ceiling, in decimal.
REQ-003 clk  input  1  single system clock; all state changes on its rising edge.
REQ-004 EN  input  1  reset, asynchronous, active-low; low clears the block, high runs it.
REQ-005 coin1  input  1  button input for a 1-unit coin; asynchronous level.
REQ-006 coin5  input  1  button input for a 5-unit coin; asynchronous level.
REQ-007 coin10  input  1  button input for a 10-unit coin; asynchronous level.
REQ-008 costone  input  4  BCD ones digit of the price.
REQ-009 costten  input  4  BCD tens digit of the price.
REQ-010 cancel  input  1  timeout/abort request from the countdown display block; level.
REQ-011 paidone  output  4  BCD ones digit of the accumulated credit.
REQ-012 paidten  output  4  BCD tens digit of the accumulated credit.
REQ-013 changeone  output  4  BCD ones digit of the change or refund amount.
REQ-014 changeten  output  4  BCD tens digit of the change or refund amount.
REQ-015 paid_ok  output  1  high while the state is PAID.
REQ-016 refund  output  1  high while the state is REFUND.

Function
REQ-017 Each coin input SHALL pass through a 2-flop synchronizer, then a debouncer that emits exactly one 1-cycle credit pulse per press, once the synchronized level has been high for DEBOUNCE cycles.
REQ-018 The debouncer SHALL re-arm only after the synchronized level has been low for DEBOUNCE cycles.
REQ-019 FSM states SHALL be COLLECT, PAID and REFUND; reset enters COLLECT.
REQ-020 In COLLECT, a credit pulse SHALL add its value (1, 5 or 10) to paidten:paidone in BCD, with the ones digit carrying into the tens digit; registered result visible the cycle after the pulse.
REQ-021 If multiple credit pulses occur in one cycle, only the highest-value pulse SHALL be credited (coin10 > coin5 > coin1); the others are dropped.
REQ-022 A credit that would push the total above MAXPAID SHALL be ignored, leaving the total unchanged.
REQ-023 Transition to PAID SHALL occur in the cycle after the registered total becomes >= the price, provided the price is valid: both digits <= 9 and not 00.
REQ-024 On that transition, changeten:changeone SHALL latch (paid - price) in BCD.
REQ-025 An invalid price SHALL never cause the transition to PAID; credits are still accepted.
REQ-026 If cancel is high in COLLECT, the block SHALL enter REFUND on the next edge and latch change = paid.
REQ-027 Cancel SHALL take priority over a same-cycle credit pulse and over a same-cycle paid>=price condition; that credit is discarded.
REQ-028 PAID and REFUND SHALL be terminal until EN is low; credits, cancel and price changes are ignored there, and all outputs hold.
REQ-029 paid digits SHALL always remain valid BCD (0-9).

Reset
REQ-030 While EN is low: state COLLECT; paidone=paidten=changeone=changeten=0; paid_ok=refund=0; synchronizers, debounce counters and armed flags cleared.
REQ-031 Assertion of EN low mid-press or mid-debounce SHALL discard the pending credit.
REQ-032 After EN rises, a held button SHALL be credited only once, after DEBOUNCE cycles.

Structure
REQ-033 A shared package pay_pkg SHALL hold the state enum, the coin values 1/5/10, the BCD digit typedef and the MAXPAID default.
REQ-034 One sub-module, coin_debounce (synchronizer + counter + one-shot), SHALL be instantiated three times.
REQ-035 BCD add, BCD subtract and compare SHALL be combinational logic inside pay_collect.

Verification (DEBOUNCE=4 in benches)
REQ-036 Price 25; press coin10, coin10, coin5 -> paid 10, 20, 25; paid_ok=1 one cycle after 25; change 00.
REQ-037 Price 12; press coin10, coin5 -> paid 15, PAID, change 03; further coin1 press -> paid stays 15.
REQ-038 Price 30; press coin5, then cancel=1 -> REFUND, change 05, paid_ok=0; cancel in the same cycle as a coin10 pulse -> refund equals the pre-pulse total.
REQ-039 coin1 held high for 50 cycles with 1-cycle glitches before it -> exactly one credit; glitches shorter than 4 cycles -> no credit.
REQ-040 Price 00; press coin10 x9 -> paid 90, state stays COLLECT; next coin10 -> ignored (would give 100); coin5 -> 95.
REQ-041 Drive EN low after 3 debounce cycles of a coin10 press -> all outputs 0; EN high with button still held -> single credit, paid 10.
